// File: rtl/z80_bus_seq_if.sv
// Request/bus bundle between the control unit, the z80_bus_seq sequencer and the external bus.
// The slave modport is the sequencer's view; the master modport is the CU/bus environment.
interface z80_bus_seq_if #(
    parameter int unsigned AddrW = 16,
    parameter int unsigned DataW = 8
);
    logic             req_valid;
    logic [2:0]       req_type;
    logic [AddrW-1:0] req_addr;
    logic [DataW-1:0] req_wdata;
    logic             req_ready;
    logic             done;
    logic [DataW-1:0] rdata;
    logic [AddrW-1:0] addr_out;
    logic [DataW-1:0] dout;
    logic [DataW-1:0] din;
    logic             m1_n;
    logic             mreq_n;
    logic             iorq_n;
    logic             rd_n;
    logic             wr_n;
    logic             rfsh_n;
    logic             wait_n;
    logic             busreq_n;
    logic             busack_n;
    logic             bus_en;

    modport master (
        output req_valid, req_type, req_addr, req_wdata, din, wait_n, busreq_n,
        input  req_ready, done, rdata, addr_out, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n,
               rfsh_n, busack_n, bus_en
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, din, wait_n, busreq_n,
        output req_ready, done, rdata, addr_out, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n,
               rfsh_n, busack_n, bus_en
    );
endinterface

// File: rtl/z80_bus_seq.sv
// Z80 machine-cycle sequencer: turns single-cycle CU requests into T-state bus sequences
// (M1 fetch with refresh, memory and IO read/write), with wait states and bus hand-over.
module z80_bus_seq #(
    parameter int unsigned AddrW  = 16,
    parameter int unsigned DataW  = 8,
    parameter int unsigned IoWait = 1,
    parameter int unsigned RBits  = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    z80_bus_seq_if.slave  bus_io
);
    localparam logic [2:0] TypeFetch = 3'd0;
    localparam logic [2:0] TypeMemRd = 3'd1;
    localparam logic [2:0] TypeMemWr = 3'd2;
    localparam logic [2:0] TypeIoRd  = 3'd3;
    localparam logic [2:0] TypeIoWr  = 3'd4;

    typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3, StT4, StGrant} state_e;

    state_e             state_q;
    logic [2:0]         type_q;
    logic [1:0]         wcnt_q;
    logic [RBits-1:0]   r_q;
    logic               idle_q;
    logic [AddrW-1:0]   addr_out_q;
    logic [DataW-1:0]   dout_q;
    logic [DataW-1:0]   rdata_q;
    logic               done_q;
    logic               m1_n_q, mreq_n_q, iorq_n_q, rd_n_q, wr_n_q, rfsh_n_q;
    logic               busack_n_q, bus_en_q;

    logic req_ready, accept, is_fetch, is_read, is_io, io_forced, to_t3;

    always_comb begin
        req_ready = idle_q & bus_io.busreq_n;
        accept    = bus_io.req_valid & req_ready;
        is_fetch  = (type_q == TypeFetch);
        is_read   = type_q inside {TypeFetch, TypeMemRd, TypeIoRd};
        is_io     = type_q inside {TypeIoRd, TypeIoWr};
        io_forced = is_io && (IoWait != 0);
        // In T2 forced IO waits take precedence; in TW they must be used up first.
        to_t3     = bus_io.wait_n && ((state_q == StT2) ? !io_forced : (wcnt_q == 2'd0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            type_q     <= TypeFetch;
            wcnt_q     <= 2'd0;
            r_q        <= '0;
            idle_q     <= 1'b0;
            addr_out_q <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            m1_n_q     <= 1'b1;
            mreq_n_q   <= 1'b1;
            iorq_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rfsh_n_q   <= 1'b1;
            busack_n_q <= 1'b1;
            bus_en_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!bus_io.busreq_n) begin
                        state_q    <= StGrant;
                        idle_q     <= 1'b0;
                        busack_n_q <= 1'b0;
                        bus_en_q   <= 1'b0;
                    end else if (accept) begin
                        type_q <= bus_io.req_type;
                        idle_q <= 1'b0;
                        if (bus_io.req_type > TypeIoWr) begin
                            // Reserved type: no bus activity, just acknowledge.
                            state_q <= StT3;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StT1;
                            addr_out_q <= bus_io.req_addr;
                            if (bus_io.req_type inside {TypeMemWr, TypeIoWr}) begin
                                dout_q <= bus_io.req_wdata;
                            end
                            m1_n_q   <= (bus_io.req_type != TypeFetch);
                            mreq_n_q <= !(bus_io.req_type inside {TypeFetch, TypeMemRd,
                                                                  TypeMemWr});
                            rd_n_q   <= !(bus_io.req_type inside {TypeFetch, TypeMemRd});
                        end
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                StT1: begin
                    state_q <= StT2;
                    wr_n_q  <= !(type_q inside {TypeMemWr, TypeIoWr});
                    if (is_io) begin
                        iorq_n_q <= 1'b0;
                        rd_n_q   <= (type_q != TypeIoRd);
                    end
                end
                StT2, StTw: begin
                    if (to_t3) begin
                        state_q <= StT3;
                        if (is_read) rdata_q <= bus_io.din;
                        if (is_fetch) begin
                            m1_n_q     <= 1'b1;
                            rd_n_q     <= 1'b1;
                            rfsh_n_q   <= 1'b0;
                            addr_out_q <= AddrW'(r_q);
                        end else begin
                            mreq_n_q <= 1'b1;
                            iorq_n_q <= 1'b1;
                            rd_n_q   <= 1'b1;
                            wr_n_q   <= 1'b1;
                            done_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= StTw;
                        if (state_q == StT2) begin
                            wcnt_q <= io_forced ? 2'(IoWait - 1) : 2'd0;
                        end else if (wcnt_q != 2'd0) begin
                            wcnt_q <= wcnt_q - 2'd1;
                        end
                    end
                end
                StT3: begin
                    if (is_fetch) begin
                        state_q  <= StT4;
                        mreq_n_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        idle_q  <= 1'b1;
                    end
                end
                StT4: begin
                    state_q  <= StIdle;
                    idle_q   <= 1'b1;
                    rfsh_n_q <= 1'b1;
                    r_q      <= r_q + 1'b1;
                end
                StGrant: begin
                    if (bus_io.busreq_n) begin
                        state_q    <= StIdle;
                        idle_q     <= 1'b1;
                        busack_n_q <= 1'b1;
                        bus_en_q   <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.req_ready = req_ready;
    assign bus_io.done      = done_q;
    assign bus_io.rdata     = rdata_q;
    assign bus_io.addr_out  = addr_out_q;
    assign bus_io.dout      = dout_q;
    assign bus_io.m1_n      = m1_n_q;
    assign bus_io.mreq_n    = mreq_n_q;
    assign bus_io.iorq_n    = iorq_n_q;
    assign bus_io.rd_n      = rd_n_q;
    assign bus_io.wr_n      = wr_n_q;
    assign bus_io.rfsh_n    = rfsh_n_q;
    assign bus_io.busack_n  = busack_n_q;
    assign bus_io.bus_en    = bus_en_q;
endmodule

// File: tb/tb_z80_bus_seq.sv
// Directed bench for z80_bus_seq: cycle-accurate strobe/done/rdata checks for each cycle type,
// refresh counter wrap, bus hand-over and asynchronous reset mid-cycle.
module tb_z80_bus_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    z80_bus_seq_if #(.AddrW(16), .DataW(8)) bus_if ();

    z80_bus_seq #(.AddrW(16), .DataW(8), .IoWait(1), .RBits(7)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request at a negedge where the sequencer is idle; returns in cycle 1 (T1).
    task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd);
        check("req_ready_before_issue", bus_if.req_ready, 1);
        bus_if.req_valid = 1'b1;
        bus_if.req_type  = t;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        step();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic fetch_cycle(input logic [15:0] a, input logic [7:0] d, input logic [6:0] r);
        bus_if.din = d;
        issue(3'd0, a, 8'h00);
        check("f_t1_m1", bus_if.m1_n, 0);
        check("f_t1_mreq", bus_if.mreq_n, 0);
        check("f_t1_rd", bus_if.rd_n, 0);
        check("f_t1_addr", bus_if.addr_out, a);
        step();
        check("f_t2_m1", bus_if.m1_n, 0);
        check("f_t2_rd", bus_if.rd_n, 0);
        check("f_t2_done", bus_if.done, 0);
        step();
        check("f_t3_m1", bus_if.m1_n, 1);
        check("f_t3_rd", bus_if.rd_n, 1);
        check("f_t3_mreq", bus_if.mreq_n, 0);
        check("f_t3_rfsh", bus_if.rfsh_n, 0);
        check("f_t3_raddr", bus_if.addr_out, {9'd0, r});
        check("f_t3_done", bus_if.done, 0);
        check("f_t3_rdata", bus_if.rdata, d);
        step();
        check("f_t4_rfsh", bus_if.rfsh_n, 0);
        check("f_t4_mreq", bus_if.mreq_n, 1);
        check("f_t4_done", bus_if.done, 1);
        check("f_t4_raddr", bus_if.addr_out, {9'd0, r});
        step();
        check("f_idle_done", bus_if.done, 0);
        check("f_idle_rfsh", bus_if.rfsh_n, 1);
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_type  = 3'd0;
        bus_if.req_addr  = 16'h0000;
        bus_if.req_wdata = 8'h00;
        bus_if.din       = 8'h00;
        bus_if.wait_n    = 1'b1;
        bus_if.busreq_n  = 1'b1;

        // Reset state
        step();
        check("rst_req_ready", bus_if.req_ready, 0);
        check("rst_strobes", {bus_if.m1_n, bus_if.mreq_n, bus_if.iorq_n, bus_if.rd_n,
                              bus_if.wr_n, bus_if.rfsh_n}, 6'b111111);
        check("rst_busack", bus_if.busack_n, 1);
        check("rst_bus_en", bus_if.bus_en, 1);
        check("rst_done", bus_if.done, 0);
        check("rst_rdata", bus_if.rdata, 0);
        check("rst_addr", bus_if.addr_out, 0);
        check("rst_dout", bus_if.dout, 0);
        rst_n = 1'b1;
        step();

        // Memory read, no waits: done in cycle 3
        bus_if.din = 8'h3E;
        issue(3'd1, 16'h1234, 8'h00);
        check("mr_t1_mreq", bus_if.mreq_n, 0);
        check("mr_t1_rd", bus_if.rd_n, 0);
        check("mr_t1_m1", bus_if.m1_n, 1);
        check("mr_t1_addr", bus_if.addr_out, 16'h1234);
        check("mr_t1_ready", bus_if.req_ready, 0);
        step();
        check("mr_t2_mreq_rd", {bus_if.mreq_n, bus_if.rd_n}, 2'b00);
        check("mr_t2_done", bus_if.done, 0);
        step();
        check("mr_t3_done", bus_if.done, 1);
        check("mr_t3_rdata", bus_if.rdata, 8'h3E);
        check("mr_t3_strobes", {bus_if.mreq_n, bus_if.rd_n}, 2'b11);
        step();
        check("mr_idle_done", bus_if.done, 0);

        // Fetches advance R: 0..4, then the R=5 fetch at 0x0000, then up to the wrap
        for (int i = 0; i < 5; i++) fetch_cycle(16'h0100 + 16'(i), 8'(i + 1), 7'(i));
        fetch_cycle(16'h0000, 8'hC6, 7'd5);
        for (int i = 6; i < 128; i++) fetch_cycle(16'h0200 + 16'(i), 8'(i), 7'(i));
        fetch_cycle(16'h0300, 8'h5D, 7'd0);

        // Memory write with two wait states: done in cycle 5
        issue(3'd2, 16'h8000, 8'h47);
        check("mw_t1_mreq", bus_if.mreq_n, 0);
        check("mw_t1_wr", bus_if.wr_n, 1);
        check("mw_t1_dout", bus_if.dout, 8'h47);
        bus_if.wait_n = 1'b0;
        step();
        check("mw_t2_wr", bus_if.wr_n, 0);
        check("mw_t2_rd", bus_if.rd_n, 1);
        step();
        check("mw_tw1_wr", bus_if.wr_n, 0);
        check("mw_tw1_done", bus_if.done, 0);
        step();
        check("mw_tw2_wr", bus_if.wr_n, 0);
        check("mw_tw2_mreq", bus_if.mreq_n, 0);
        check("mw_tw2_done", bus_if.done, 0);
        bus_if.wait_n = 1'b1;
        step();
        check("mw_t3_done", bus_if.done, 1);
        check("mw_t3_wr", bus_if.wr_n, 1);
        check("mw_t3_dout", bus_if.dout, 8'h47);
        step();

        // IO read with one forced wait: done in cycle 4
        bus_if.din = 8'h90;
        issue(3'd3, 16'h0010, 8'h00);
        check("ir_t1_strobes", {bus_if.mreq_n, bus_if.iorq_n, bus_if.rd_n}, 3'b111);
        check("ir_t1_addr", bus_if.addr_out, 16'h0010);
        step();
        check("ir_t2_iorq_rd", {bus_if.iorq_n, bus_if.rd_n, bus_if.mreq_n}, 3'b001);
        step();
        check("ir_tw_iorq_rd", {bus_if.iorq_n, bus_if.rd_n}, 2'b00);
        check("ir_tw_done", bus_if.done, 0);
        step();
        check("ir_t3_done", bus_if.done, 1);
        check("ir_t3_rdata", bus_if.rdata, 8'h90);
        check("ir_t3_iorq", bus_if.iorq_n, 1);
        step();

        // IO write
        issue(3'd4, 16'h0055, 8'hA5);
        check("iw_t1_dout", bus_if.dout, 8'hA5);
        step();
        check("iw_t2_strobes", {bus_if.iorq_n, bus_if.wr_n, bus_if.rd_n}, 3'b001);
        step();
        check("iw_tw_done", bus_if.done, 0);
        step();
        check("iw_t3_done", bus_if.done, 1);
        check("iw_t3_wr", bus_if.wr_n, 1);
        step();

        // Reserved type: done one cycle later, no strobes, rdata kept
        bus_if.din = 8'hEE;
        issue(3'd6, 16'h7777, 8'h00);
        check("rsv_done", bus_if.done, 1);
        check("rsv_strobes", {bus_if.m1_n, bus_if.mreq_n, bus_if.iorq_n, bus_if.rd_n,
                              bus_if.wr_n, bus_if.rfsh_n}, 6'b111111);
        check("rsv_rdata", bus_if.rdata, 8'h90);
        step();
        check("rsv_done_clr", bus_if.done, 0);
        step();

        // Bus request during T2 of a read: read finishes, then grant, then queued request
        bus_if.din = 8'h11;
        issue(3'd1, 16'h4321, 8'h00);
        step();
        bus_if.busreq_n = 1'b0;
        step();
        check("br_t3_done", bus_if.done, 1);
        check("br_t3_rdata", bus_if.rdata, 8'h11);
        check("br_t3_busack", bus_if.busack_n, 1);
        bus_if.req_valid = 1'b1;
        bus_if.req_type  = 3'd1;
        bus_if.req_addr  = 16'h0042;
        bus_if.din       = 8'h22;
        step();
        check("br_idle_ready", bus_if.req_ready, 0);
        check("br_idle_busack", bus_if.busack_n, 1);
        step();
        check("br_grant_busack", bus_if.busack_n, 0);
        check("br_grant_bus_en", bus_if.bus_en, 0);
        check("br_grant_ready", bus_if.req_ready, 0);
        check("br_grant_mreq", bus_if.mreq_n, 1);
        step();
        check("br_hold_busack", bus_if.busack_n, 0);
        bus_if.busreq_n = 1'b1;
        step();
        check("br_rel_busack", bus_if.busack_n, 1);
        check("br_rel_bus_en", bus_if.bus_en, 1);
        check("br_rel_ready", bus_if.req_ready, 1);
        step();
        bus_if.req_valid = 1'b0;
        check("br_q_t1_mreq", bus_if.mreq_n, 0);
        check("br_q_t1_addr", bus_if.addr_out, 16'h0042);
        step();
        step();
        check("br_q_t3_done", bus_if.done, 1);
        check("br_q_t3_rdata", bus_if.rdata, 8'h22);
        step();

        // Asynchronous reset during TW of a write
        issue(3'd2, 16'h9000, 8'h5A);
        bus_if.wait_n = 1'b0;
        step();
        step();
        check("rw_tw_wr", bus_if.wr_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_rst_wr", bus_if.wr_n, 1);
        check("rw_rst_mreq", bus_if.mreq_n, 1);
        check("rw_rst_done", bus_if.done, 0);
        check("rw_rst_dout", bus_if.dout, 0);
        bus_if.wait_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("rw_post_ready", bus_if.req_ready, 1);
        check("rw_post_done", bus_if.done, 0);
        fetch_cycle(16'h0400, 8'h77, 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/z80_bus_seq.md
Name: z80_bus_seq

Overview:
- Machine-cycle sequencer between the z80_cu and the external memory/IO bus.
- Turns single-cycle requests from the control unit into Z80-style T-state sequences: opcode fetch (M1), memory read/write and IO read/write.
- Handles wait-state insertion, refresh-address generation and bus hand-over to an external master through BUSREQ/BUSACK.
- Sits in z80_core between the CU/regfile address path and program memory.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- IO_WAIT, 1, automatic wait states inserted in every IO cycle (0..3).
- R_BITS, 7, width of the refresh counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CU requests a machine cycle.
- req_type  in  3  0 fetch, 1 mem read, 2 mem write, 3 io read, 4 io write; 5-7 reserved.
- req_addr  in  ADDR_W  cycle address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  sequencer accepts a request this cycle.
- done  out  1  one-cycle pulse when the cycle completes.
- rdata  out  DATA_W  captured read/fetch data; held until the next capture.
- addr_out  out  ADDR_W  bus address.
- dout  out  DATA_W  bus write data.
- din  in  DATA_W  bus read data.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  out  1 each  active-low bus strobes.
- wait_n  in  1  memory/IO wait request, active low.
- busreq_n  in  1  external master requests the bus.
- busack_n  out  1  bus granted to the external master.
- bus_en  out  1  high while this block drives addr/dout/strobes.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; all strobes and busack_n high; bus_en 1; req_ready 0 while reset is low.
  - done 0; rdata 0; addr_out 0; dout 0; refresh counter 0.
- States: IDLE, T1, T2, TW, T3, T4, GRANT. All outputs are registered.
- req_ready = (state==IDLE) & busreq_n. A request is accepted on the edge where req_valid & req_ready; type, addr and wdata are latched at that edge.
- Reserved req_type: request is accepted, no strobes are asserted, done pulses 1 cycle later, and rdata is unchanged.
- IDLE:
  - busreq_n low has priority over req_valid -> GRANT.
  - otherwise an accepted request -> T1.
- T1:
  - addr_out = latched address.
  - m1_n low for fetch.
  - mreq_n and rd_n low for fetch and mem read.
  - mreq_n low and dout driven for mem write.
  - -> T2.
- T2:
  - wr_n low for mem write; iorq_n low plus rd_n or wr_n for IO.
  - IO with IO_WAIT>0 -> TW for exactly IO_WAIT cycles, then wait_n is honoured.
  - otherwise wait_n low -> TW, else -> T3.
- TW: strobes held; stay while wait_n low or forced IO waits remain; else -> T3.
- Read capture: rdata <= din on the edge leaving T2/TW toward T3 (fetch, mem read, io read).
- T3, non-fetch:
  - all strobes high; done=1.
  - -> IDLE.
  - Read latency with no waits: done is high in the 3rd cycle after acceptance.
- T3, fetch (refresh):
  - m1_n and rd_n high.
  - addr_out = {zeros, R}; mreq_n low; rfsh_n low.
  - -> T4.
- T4, fetch:
  - rfsh_n low; mreq_n high.
  - done=1.
  - R <= R+1, wrapping 2^R_BITS-1 -> 0.
  - -> IDLE.
- GRANT:
  - entered only from IDLE, so an in-progress cycle is never interrupted.
  - busack_n low; bus_en low; strobes high.
  - Stay while busreq_n low; busreq_n high -> IDLE, with busack_n high and bus_en high in the same cycle as the IDLE state.
- busreq_n asserted mid-cycle: the cycle completes normally, then GRANT is entered from the following IDLE.
- wait_n is ignored outside T2/TW.
- req_valid while req_ready=0: ignored; the CU holds the request.
- Reset mid-cycle: strobes release at once, and no done pulse is produced.

Test Plan:
- Mem read at 0x1234, din=0x3E, wait_n=1 -> T1,T2,T3; mreq_n/rd_n low in T1-T2; done in cycle 3; rdata=0x3E.
- Fetch at 0x0000, din=0xC6, R=5 -> m1_n low in T1-T2; then addr_out=0x0005 with rfsh_n low in T3-T4; done in cycle 4; rdata=0xC6; R becomes 6. Also with R=0x7F -> R becomes 0x00.
- Mem write at 0x8000, wdata=0x47, wait_n low for 2 cycles starting in T2 -> wr_n low from T2 through 2 TW; done in cycle 5; dout=0x47 throughout.
- IO read port 0x0010, IO_WAIT=1, din=0x90, wait_n=1 -> iorq_n/rd_n low T2+1 TW; rdata=0x90; done in cycle 4.
- busreq_n falls during T2 of a mem read -> read completes with done; next cycle GRANT with busack_n=0, bus_en=0, req_ready=0. Release busreq_n -> busack_n=1 one cycle later; a queued request is then accepted.
- reset low during TW of a write -> wr_n and mreq_n high immediately; done=0; after release, state IDLE and req_ready=1.
